// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter:
// FSM state encoding, port ids and counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector.
// Ports: i_req {d,c} request pair, i_last last owner, o_win winner.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_win
);

  always_comb begin
    o_win = i_last;
    case (i_req)
      2'b01:   o_win = PORT_C;
      2'b10:   o_win = PORT_D;
      // tie: whoever did not own the memory last
      2'b11:   o_win = ~i_last;
      default: o_win = i_last;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one strobe-driven sync memory between the
// controller (c) and loader (d) ports with round-robin req/ack.
// Ports: c_*/d_* requester sides, mem_* memory side,
// rdata last read data, busy (not idle), gnt current/last owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_addr_en,
  output logic          mem_in_en,
  output logic          mem_out_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt
);

  generate
    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
      $error("mem_arbiter: ACCESS_CYCLES must be 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(ACCESS_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_gnt;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW-1:0]     r_rdata;
  logic              w_win;
  logic              w_any;
  logic              w_last;

  assign w_any  = c_req | d_req;
  assign w_last = (r_cnt == '0);

  rr_pick2 u_pick (
    .i_req  ({d_req, c_req}),
    .i_last (r_gnt),
    .o_win  (w_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next = ST_ADDR;
      ST_ADDR:   w_next = ST_ACCESS;
      ST_ACCESS: if (w_last) w_next = ST_ACK;
      ST_ACK:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_gnt   <= PORT_D;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_we    <= w_win ? d_we    : c_we;
            r_addr  <= w_win ? d_addr  : c_addr;
            r_wdata <= w_win ? d_wdata : c_wdata;
          end
        end
        ST_ADDR: r_cnt <= CNT_INIT;
        ST_ACCESS: begin
          if (w_last) begin
            if (!r_we) r_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_en = (r_state == ST_ADDR);
  assign mem_in_en   = (r_state == ST_ACCESS) &  r_we;
  assign mem_out_en  = (r_state == ST_ACCESS) & ~r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign rdata       = r_rdata;
  assign busy        = (r_state != ST_IDLE);
  assign gnt         = r_gnt;
  assign c_ack = (r_state == ST_ACK) & (r_gnt == PORT_C);
  assign d_ack = (r_state == ST_ACK) & (r_gnt == PORT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance plus
// an ACCESS_CYCLES=3 instance, each with its own memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [15:0] c_addr = 0, c_wdata = 0;
  logic [15:0] d_addr = 0, d_wdata = 0;
  logic        c_ack, d_ack, addr_en, in_en, out_en;
  logic        busy, gnt;
  logic [15:0] rdata, maddr, mwdata, mrdata;

  logic        c3_req = 0;
  logic [15:0] c3_addr = 0;
  logic        z1 = 0;
  logic [15:0] z16 = 0;
  logic        c3_ack, d3_ack, addr_en3, in_en3, out_en3;
  logic        busy3, gnt3;
  logic [15:0] rdata3, maddr3, mwdata3, mrdata3;

  mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mem_addr_en(addr_en),
    .mem_in_en(in_en), .mem_out_en(out_en),
    .mem_addr(maddr), .mem_wdata(mwdata),
    .mem_rdata(mrdata), .busy(busy), .gnt(gnt)
  );

  mem_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .c_req(c3_req), .c_we(z1), .c_addr(c3_addr),
    .c_wdata(z16), .c_ack(c3_ack),
    .d_req(z1), .d_we(z1), .d_addr(z16),
    .d_wdata(z16), .d_ack(d3_ack),
    .rdata(rdata3), .mem_addr_en(addr_en3),
    .mem_in_en(in_en3), .mem_out_en(out_en3),
    .mem_addr(maddr3), .mem_wdata(mwdata3),
    .mem_rdata(mrdata3), .busy(busy3), .gnt(gnt3)
  );

  // memory model for the default instance
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) mem[16] <= 16'hBEEF;
    else if (in_en) mem[maddr[7:0]] <= mwdata;
  end
  assign mrdata = mem[maddr[7:0]];

  // read data that changes every strobe cycle
  logic [15:0] cnt3;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt3 <= 16'd0;
    else if (out_en3) cnt3 <= cnt3 + 16'd1;
  end
  assign mrdata3 = 16'hA000 + cnt3;

  int n_chk = 0;
  int n_fail = 0;
  int n_ovl = 0;
  int n_dack = 0;

  always @(negedge clk) begin
    if (32'(addr_en) + 32'(in_en) + 32'(out_en) > 1)
      n_ovl <= n_ovl + 1;
    if (d_ack) n_dack <= n_dack + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int snap;
  int ack_cyc[$];
  logic ack_prt[$];

  initial begin
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_maddr", 32'(maddr), 32'd0);
    chk("rst_strb", {29'd0, addr_en, in_en, out_en}, 32'd0);
    chk("rst_ack", {30'd0, c_ack, d_ack}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: controller read of 0x0010
    snap = n_dack;
    c_req = 1; c_we = 0; c_addr = 16'h0010;
    tick();
    chk("t1_aen", 32'(addr_en), 32'd1);
    chk("t1_oen0", 32'(out_en), 32'd0);
    tick();
    chk("t1_oen", 32'(out_en), 32'd1);
    chk("t1_maddr", 32'(maddr), 32'h10);
    tick();
    chk("t1_cack", 32'(c_ack), 32'd1);
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    chk("t1_gnt", 32'(gnt), 32'd0);
    c_req = 0;
    tick();
    chk("t1_idle", {30'd0, busy, c_ack}, 32'd0);
    chk("t1_nodack", 32'(n_dack - snap), 32'd0);

    // T2: loader write, then controller read-back
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick();
    chk("t2_gnt", 32'(gnt), 32'd1);
    tick();
    chk("t2_ien", {30'd0, in_en, out_en}, 32'd2);
    chk("t2_maddr", 32'(maddr), 32'h20);
    chk("t2_wdata", 32'(mwdata), 32'h1234);
    tick();
    chk("t2_dack", {30'd0, c_ack, d_ack}, 32'd1);
    chk("t2_rkeep", 32'(rdata), 32'hBEEF);
    d_req = 0; d_we = 0;
    tick();
    c_req = 1; c_addr = 16'h0020;
    repeat (3) tick();
    chk("t2_cack", 32'(c_ack), 32'd1);
    chk("t2_rback", 32'(rdata), 32'h1234);
    c_req = 0;
    tick();

    // T3: both held from reset -> c,d,c,d every 4 cycles
    rst = 1; tick(); rst = 0; tick();
    c_req = 1; c_addr = 16'h0010;
    d_req = 1; d_addr = 16'h0020;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (c_ack) begin ack_cyc.push_back(i); ack_prt.push_back(0); end
      if (d_ack) begin ack_cyc.push_back(i); ack_prt.push_back(1); end
    end
    c_req = 0; d_req = 0;
    chk("t3_nack", 32'(ack_cyc.size()), 32'd4);
    if (ack_cyc.size() == 4) begin
      chk("t3_first", 32'(ack_cyc[0]), 32'd2);
      for (int k = 0; k < 4; k++) begin
        chk("t3_order", 32'(ack_prt[k]), 32'(k % 2));
        if (k > 0)
          chk("t3_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
      end
    end
    chk("t3_last_rd", 32'(rdata), 32'h1234);
    tick();

    // T4: ACCESS_CYCLES=3 controller read
    c3_req = 1; c3_addr = 16'h0040;
    tick();
    chk("t4_aen", 32'(addr_en3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_oen", {30'd0, out_en3, c3_ack}, 32'd2);
    end
    tick();
    chk("t4_cack", {30'd0, c3_ack, out_en3}, 32'd2);
    chk("t4_rdata", 32'(rdata3), 32'hA002);
    chk("t4_dack", 32'(d3_ack), 32'd0);
    c3_req = 0;
    tick();
    chk("t4_idle", 32'(busy3), 32'd0);

    // T5: reset in the middle of a loader write
    snap = n_dack;
    d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'h5555;
    tick(); tick();
    chk("t5_ien", 32'(in_en), 32'd1);
    #1 rst = 1;
    #1;
    chk("t5_strb", {29'd0, addr_en, in_en, out_en}, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_gnt", 32'(gnt), 32'd1);
    d_req = 0; d_we = 0;
    tick(); tick();
    chk("t5_nodack", 32'(n_dack - snap), 32'd0);
    #2 rst = 0;
    tick();
    c_req = 1; c_addr = 16'h0010;
    d_req = 1; d_addr = 16'h0020;
    tick();
    chk("t5_cwin", 32'(gnt), 32'd0);
    chk("t5_maddr", 32'(maddr), 32'h10);
    tick(); tick();
    chk("t5_cack", {30'd0, c_ack, d_ack}, 32'd2);
    chk("t5_rdata", 32'(rdata), 32'hBEEF);
    c_req = 0; d_req = 0;
    tick();

    // T6: req dropped in ADDR still completes, once
    c_req = 1; c_addr = 16'h0020;
    tick();
    c_req = 0;
    tick(); tick();
    chk("t6_cack", 32'(c_ack), 32'd1);
    chk("t6_rdata", 32'(rdata), 32'h1234);
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    tick();
    chk("t6_noreq", {30'd0, busy, addr_en}, 32'd0);

    chk("ovl", 32'(n_ovl), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
